// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Items shared by the CPU control blocks.
//   REG_AW_DEF    : default register-address width
//   pctrl_state_t : lifecycle states of pipeline_ctrl
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    PC_IDLE  = 2'd0,
    PC_RUN   = 2'd1,
    PC_DRAIN = 2'd2,
    PC_DONE  = 2'd3
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use compare. The forwarding unit can reuse it.
// The result is raw: the caller decides in which states it is allowed to
// stall.
//   idex_mem_read_i : ID/EX instruction is a load
//   idex_rd_i       : destination register of the ID/EX instruction
//   ifid_rs_i       : rs of the IF/ID instruction
//   ifid_rt_i       : rt of the IF/ID instruction
//   ifid_uses_rt_i  : IF/ID instruction actually reads rt
//   stall_raw_o     : load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              idex_mem_read_i,
  input  logic [REG_AW-1:0] idex_rd_i,
  input  logic [REG_AW-1:0] ifid_rs_i,
  input  logic [REG_AW-1:0] ifid_rt_i,
  input  logic              ifid_uses_rt_i,
  output logic              stall_raw_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rd_i == ifid_rs_i);
  // An rt compare only matters when the instruction really reads rt.
  assign rt_match = ifid_uses_rt_i && (idex_rd_i == ifid_rt_i);

  // Register 0 is hardwired to zero, so a load into it never creates a hazard.
  assign stall_raw_o = idex_mem_read_i && (idex_rd_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Sequencing controller for the 5-stage CPU. It runs the IDLE/RUN/DRAIN/DONE
// lifecycle and inserts one bubble per load-use hazard. It flushes IF/ID and
// ID/EX on a taken branch and drains the pipe after HALT.
//
// Optional feature: define PIPELINE_CTRL_PERF_CNT_EN to add the saturating
// cycle_cnt / stall_cnt performance counters and their ports.
//
// Ports
//   clk, rst               : clock (rising edge), async active-low reset
//   start                  : start request, honoured in IDLE/DONE only
//   idex_mem_read, idex_rd : load in ID/EX and its destination
//   ifid_rs, ifid_rt,
//   ifid_uses_rt           : sources of the IF/ID instruction
//   id_halt                : IF/ID instruction is HALT
//   exmem_branch_taken     : branch in EX/MEM resolved taken
//   pc_en, ifid_en         : PC / IF/ID write enables (Mealy)
//   ifid_flush, idex_flush : synchronous clears to NOP (Mealy)
//   busy, done             : RUN|DRAIN / DONE, decoded from state (Moore)
//   dbg_state              : current FSM state, for observation
//   stall_cnt, cycle_cnt   : perf counters (PIPELINE_CTRL_PERF_CNT_EN only)
//
// Handshake: there is no valid/ready pair. start is a level that is sampled
// at every rising edge while the state is IDLE or DONE and ignored otherwise.
// ---------------------------------------------------------------------------
module pipeline_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned REG_AW       = REG_AW_DEF,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              idex_mem_read,
  input  logic [REG_AW-1:0] idex_rd,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic              id_halt,
  input  logic              exmem_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              busy,
  output logic              done,
  output pctrl_state_t      dbg_state
`ifdef PIPELINE_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  cycle_cnt
`endif
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  pctrl_state_t  state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic stall_raw;
  logic stall;
  logic branch;
  logic in_run;
  logic in_drain;
  logic start_run;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .idex_mem_read_i (idex_mem_read),
    .idex_rd_i       (idex_rd),
    .ifid_rs_i       (ifid_rs),
    .ifid_rt_i       (ifid_rt),
    .ifid_uses_rt_i  (ifid_uses_rt),
    .stall_raw_o     (stall_raw)
  );

  assign in_run    = (state_q == PC_RUN);
  assign in_drain  = (state_q == PC_DRAIN);
  assign branch    = exmem_branch_taken;
  assign stall     = in_run && stall_raw;
  assign start_run = ((state_q == PC_IDLE) || (state_q == PC_DONE)) && start;

  // Next-state logic. A taken branch wins over stall and HALT. A HALT that
  // shares a cycle with a branch is on the wrong path and gets flushed.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      PC_IDLE, PC_DONE: begin
        if (start) state_d = PC_RUN;
      end
      PC_RUN: begin
        if (!branch && !stall_raw && id_halt) begin
          state_d = PC_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      PC_DRAIN: begin
        // The branch is older than HALT, so the program continues.
        if (branch) begin
          state_d = PC_RUN;
        end else if (drain_q == '0) begin
          state_d = PC_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = PC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PC_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Mealy enables and flushes. Stall and flush act at the same edge they
  // are detected.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (in_run || in_drain) begin
      if (branch) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (in_drain) begin
        // Fetch is frozen and the instruction behind HALT is squashed.
        ifid_flush = 1'b1;
      end else if (stall) begin
        // Hold PC and IF/ID and send one bubble down to EX.
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  assign busy      = in_run || in_drain;
  assign done      = (state_q == PC_DONE);
  assign dbg_state = state_q;

`ifdef PIPELINE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;

  // Saturating counters. They restart on every new run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (start_run) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (busy && (cycle_q != '1)) cycle_q <= cycle_q + 1'b1;
      if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end
  end

  assign cycle_cnt = cycle_q;
  assign stall_cnt = stall_q;
`else
  logic unused_start_run;
  assign unused_start_run = start_run;
`endif

endmodule
